// File: rtl/motion_estimator.sv
// Integer-pel horizontal block-matching motion estimator: streams reference/current columns, reports minimum SAD.
// Optional ME_MV_OUT_EN adds the best_mv output carrying the winning displacement.
module motion_estimator #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  localparam int NCAND = SEARCH_DIM - MACRO_DIM + 1,
  localparam int CW    = $clog2(SEARCH_DIM + 1)
`ifdef ME_MV_OUT_EN
  , localparam int MVW = (NCAND > 1) ? $clog2(NCAND) : 1
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  pixel_spr_in [0:MACRO_DIM-1],
  input  logic [7:0]  pixel_cpr_in [0:MACRO_DIM-1],
  output logic        valid,
  output logic [15:0] min_sad
`ifdef ME_MV_OUT_EN
  , output logic [MVW-1:0] best_mv
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, CMP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   acc_q [0:NCAND-1];
  logic [15:0]   acc_d [0:NCAND-1];
  logic [15:0]   run_min_q, run_min_d;
  logic [7:0]    cur_q [0:MACRO_DIM-1][0:MACRO_DIM-1];
  logic          valid_d;
  logic [15:0]   min_sad_d;
`ifdef ME_MV_OUT_EN
  logic [MVW-1:0] run_mv_q, run_mv_d;
  logic [MVW-1:0] best_mv_d;
`endif

  logic [11:0] colsad;
  logic [7:0]  curpx;
  logic [7:0]  refpx;
  int          c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    run_min_d = run_min_q;
    valid_d   = 1'b0;
    min_sad_d = min_sad;
`ifdef ME_MV_OUT_EN
    run_mv_d  = run_mv_q;
    best_mv_d = best_mv;
`endif
    colsad = '0;
    curpx  = '0;
    refpx  = '0;
    c      = 0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          for (int unsigned d = 0; d < NCAND; d++) acc_d[d] = '0;
        end
      end
      LOAD: begin
        // Candidate d sees current column k-d; at d=0 that column is still on the input bus.
        for (int unsigned d = 0; d < NCAND; d++) begin
          c = int'(cnt_q) - int'(d);
          if (c >= 0 && c < MACRO_DIM) begin
            colsad = '0;
            for (int unsigned r = 0; r < MACRO_DIM; r++) begin
              curpx  = (d == 0) ? pixel_cpr_in[r] : cur_q[c][r];
              refpx  = pixel_spr_in[r];
              colsad = colsad + 12'((curpx > refpx) ? (curpx - refpx) : (refpx - curpx));
            end
            acc_d[d] = acc_q[d] + 16'(colsad);
          end
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SEARCH_DIM - 1)) begin
          state_d = CMP;
          cnt_d   = '0;
        end
      end
      CMP: begin
        // Strict less-than keeps the lowest displacement on ties.
        if (cnt_q == '0 || acc_q[cnt_q] < run_min_q) begin
          run_min_d = acc_q[cnt_q];
`ifdef ME_MV_OUT_EN
          run_mv_d  = MVW'(cnt_q);
`endif
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NCAND - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        valid_d   = 1'b1;
        min_sad_d = run_min_q;
`ifdef ME_MV_OUT_EN
        best_mv_d = run_mv_q;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '{default: '0};
      run_min_q <= '0;
      valid     <= 1'b0;
      min_sad   <= '0;
`ifdef ME_MV_OUT_EN
      run_mv_q  <= '0;
      best_mv   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      run_min_q <= run_min_d;
      valid     <= valid_d;
      min_sad   <= min_sad_d;
`ifdef ME_MV_OUT_EN
      run_mv_q  <= run_mv_d;
      best_mv   <= best_mv_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == LOAD && cnt_q < CW'(MACRO_DIM)) begin
      cur_q[cnt_q] <= pixel_cpr_in;
    end
  end

endmodule

// File: tb/tb_motion_estimator.sv
// Directed bench for motion_estimator: table of block patterns plus start/reset sequencing cases.
module tb_motion_estimator;
  localparam int MD = 16;
  localparam int SD = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  spr [0:MD-1];
  logic [7:0]  cpr [0:MD-1];
  logic        valid;
  logic [15:0] min_sad;
`ifdef ME_MV_OUT_EN
  logic [5:0]  best_mv;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  motion_estimator #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pixel_spr_in (spr),
    .pixel_cpr_in (cpr),
    .valid        (valid),
    .min_sad      (min_sad)
`ifdef ME_MV_OUT_EN
    , .best_mv    (best_mv)
`endif
  );

  typedef struct {
    string name;
    bit    has_pat;
    int    cur_u;
    int    ref_u;
    int    lo;
    int    hi;
    int    per;
    int    exp_sad;
    int    exp_mv;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(string n, bit hp, int cu, int ru, int lo, int hi, int per,
                              int es, int em);
    vec_t v;
    v.name = n; v.has_pat = hp; v.cur_u = cu; v.ref_u = ru;
    v.lo = lo; v.hi = hi; v.per = per; v.exp_sad = es; v.exp_mv = em;
    return v;
  endfunction

  function automatic logic [7:0] pat(int col, int r, int per);
    return 8'(1 + (col % per) * 12 + r);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_col(vec_t v, int k);
    for (int r = 0; r < MD; r++) begin
      if (v.has_pat && k >= v.lo && k <= v.hi) spr[r] = pat(k - v.lo, r, v.per);
      else spr[r] = 8'(v.ref_u);
      if (k >= MD) cpr[r] = 8'hA5;
      else if (v.has_pat) cpr[r] = pat(k, r, v.per);
      else cpr[r] = 8'(v.cur_u);
    end
  endtask

  task automatic set_uniform(int cu, int ru);
    for (int r = 0; r < MD; r++) begin
      cpr[r] = 8'(cu);
      spr[r] = 8'(ru);
    end
  endtask

  // Drives one full run from IDLE and checks latency, result and pulse width.
  task automatic run_vec(vec_t v);
    int n;
    bit seen;
    start = 1'b1;
    drive_col(v, 0);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < SD; k++) begin
      drive_col(v, k);
      @(posedge clk);
      #1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) seen = 1'b1;
    end
    check({v.name, "_latency"}, n, 34);
    check({v.name, "_sad"}, int'(min_sad), v.exp_sad);
`ifdef ME_MV_OUT_EN
    check({v.name, "_mv"}, int'(best_mv), v.exp_mv);
`endif
    @(posedge clk);
    #1;
    check({v.name, "_pulse1"}, int'(valid), 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < 300);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int at_edge;
    int n;

    vecs[0] = mk("zero",   0, 0,   0,   0, 0,  1,  0,     0);
    vecs[1] = mk("c10r0",  0, 10,  0,   0, 0,  1,  2560,  0);
    vecs[2] = mk("c255r0", 0, 255, 0,   0, 0,  1,  65280, 0);
    vecs[3] = mk("c3r200", 0, 3,   200, 0, 0,  1,  50432, 0);
    vecs[4] = mk("embed5", 1, 0,   255, 5, 20, 16, 0,     5);
    vecs[5] = mk("tie3_9", 1, 0,   255, 3, 24, 6,  0,     3);

    rst = 1'b1;
    start = 1'b0;
    set_uniform(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(valid), 0);
    check("reset_sad", int'(min_sad), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start toggling during LOAD/CMP must not spawn extra runs
    set_uniform(10, 0);
    pulses = 0;
    at_edge = -1;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 110; i++) begin
      #1;
      if (valid) begin
        pulses++;
        at_edge = i;
      end
      start = (i < 70) ? i[0] : 1'b0;
      @(posedge clk);
    end
    #1;
    check("toggle_pulses", pulses, 1);
    check("toggle_edge", at_edge, 82);
    check("toggle_sad", int'(min_sad), 2560);

    // start held high: back-to-back runs
    set_uniform(7, 2);
    start = 1'b1;
    wait_valid(n);
    check("held_first_sad", int'(min_sad), 1280);
    wait_valid(n);
    check("held_period1", n, 83);
    wait_valid(n);
    check("held_period2", n, 83);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("held_stop_pulses", pulses, 0);

    // reset in the middle of LOAD aborts the run
    set_uniform(9, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_valid", int'(valid), 0);
    check("midrst_sad", int'(min_sad), 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    check("midrst_pulses", pulses, 0);
    check("midrst_sad_held", int'(min_sad), 0);
    run_vec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_estimator.md
# motion_estimator

Integer-pel block-matching motion estimator for the H.264 inter-prediction path. It receives one current macroblock and a horizontal reference search strip as column streams, one column per clock. It computes the sum of absolute differences (SAD) for every horizontal candidate displacement and reports the minimum SAD with a one-cycle `valid` pulse. The block sits between the picture-buffer column fetch logic and mode decision.

## Interface
- `MACRO_DIM`, 16, macroblock width/height in pixels (rows per column, columns per block).
- `SEARCH_DIM`, 48, reference strip width in columns; must be ≥ `MACRO_DIM`. Candidate count `NCAND = SEARCH_DIM-MACRO_DIM+1` (33 at defaults).
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  level-sampled request; honoured only in IDLE.
- `pixel_spr_in`  in  8×[0:MACRO_DIM-1]  unpacked array; reference (search) column, element r = row r.
- `pixel_cpr_in`  in  8×[0:MACRO_DIM-1]  unpacked array; current-block column, element r = row r.
- `valid`  out  1  one-cycle pulse; `min_sad` is final while high.
- `min_sad`  out  16  minimum block SAD over all candidates. Unsigned; max 65280, so it never overflows.

## Operation
- States: IDLE → LOAD → CMP → DONE → IDLE.
- IDLE, `start`=1 at an edge (E0):
  - go to LOAD;
  - clear all NCAND accumulators;
  - column counter k=0.
- LOAD, edges E1..E_SEARCH_DIM, sample reference column k each edge:
  - For k < MACRO_DIM, also capture `pixel_cpr_in` as current column k into a MACRO_DIM×MACRO_DIM register. For k ≥ MACRO_DIM, `pixel_cpr_in` is ignored.
  - For every candidate d with 0 ≤ k−d < MACRO_DIM: acc[d] += Σ_r |cur[k−d][r] − ref_k[r]|.
  - When d=0, cur[k] is taken from the live `pixel_cpr_in`.
  - A column SAD is 12 bits wide; accumulators are 16 bits.
- After the edge with k = SEARCH_DIM−1 → CMP.
- CMP, one candidate per cycle in order d=0..NCAND−1:
  - the running minimum is replaced only on a strict `<`, so ties keep the smallest d;
  - after the NCAND-th compare → DONE.
- DONE: `valid`=1 for that one cycle; `min_sad` is loaded and then held until the next DONE; → IDLE.
- `start` is ignored in LOAD/CMP/DONE. If `start` is still high on returning to IDLE, a new run begins at that edge.
- Reset:
  - `rst`=1 at any edge forces IDLE;
  - `valid`=0, `min_sad`=0, accumulators and counters 0;
  - any run in progress is aborted with no `valid`.

## Timing
- Latency: with E0 the start-accept edge, `valid` is high during the cycle following edge E_(SEARCH_DIM+NCAND+1). That is E82 at defaults.
- Column k must be stable at edge E_(k+1).
- Throughput: one block per SEARCH_DIM+NCAND+2 cycles (83 at defaults). Back-to-back runs are possible with `start` held high.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `ME_MV_OUT_EN`:
  - Defined: adds output `best_mv` with width $clog2(NCAND) (minimum 1). It gives the winning displacement d under the same tie rule, resets to 0 and updates together with `min_sad`.
  - Undefined: the port and its logic are absent; `min_sad`/`valid` behaviour is identical.

## Test plan
- Reset then all-zero reference and current, defaults → single `valid` pulse at E82 with `min_sad`=0; `valid`=0 elsewhere.
- Current all 10, reference all 0 → `min_sad`=2560 (16·16·10).
- Current all 255, reference all 0 → `min_sad`=65280, with no wrap.
- Reference = current block placed at columns 5..20, other columns 0xFF, current random nonzero → `min_sad`=0; `best_mv`=5 when `ME_MV_OUT_EN` is defined. Repeat with identical matches at d=3 and d=9 → `best_mv`=3.
- `start` toggled during LOAD/CMP → ignored, exactly one `valid`. `start` held high continuously → `valid` every 83 cycles.
- `rst` asserted mid-LOAD → no `valid`, `min_sad`=0. The next run gives a correct result.
